// File: rtl/execute_mc_if.sv
// Register-read -> execute -> memory stage boundary signals.
// Stall protocol: the instruction on *_exec_next is held by upstream while
// stall_exec is high and is consumed on the first rising edge with
// stall_exec low. valid_mem_next qualifies the registered stage outputs.
// fsm_state exposes the MUL/DIV sequencer state (0 idle, 1 busy, 2 finish).
interface execute_mc_if #(
   parameter int WIDTH = 32
);
   logic             valid_exec_next;
   logic [WIDTH-1:0] pc_exec_next;
   logic [31:0]      ir_exec_next;
   logic [WIDTH-1:0] a_exec_next;
   logic [WIDTH-1:0] b_exec_next;
   logic [WIDTH-1:0] st_exec_next;
   logic             flush_exec;
   logic             stall_mem;
   logic             stall_exec;
   logic             valid_mem_next;
   logic [WIDTH-1:0] pc_mem_next;
   logic [31:0]      ir_mem_next;
   logic [WIDTH-1:0] y_mem_next;
   logic [WIDTH-1:0] st_mem_next;
   logic [1:0]       fsm_state;

   modport master (
      output valid_exec_next, pc_exec_next, ir_exec_next, a_exec_next,
             b_exec_next, st_exec_next, flush_exec, stall_mem,
      input  stall_exec, valid_mem_next, pc_mem_next, ir_mem_next,
             y_mem_next, st_mem_next, fsm_state
   );

   modport slave (
      input  valid_exec_next, pc_exec_next, ir_exec_next, a_exec_next,
             b_exec_next, st_exec_next, flush_exec, stall_mem,
      output stall_exec, valid_mem_next, pc_mem_next, ir_mem_next,
             y_mem_next, st_mem_next, fsm_state
   );
endinterface

// File: rtl/execute_mc.sv
// Beta execute stage: single-cycle ALU plus an optional iterative
// shift-add multiplier / restoring divider that stalls upstream.
module execute_mc #(
   parameter int WIDTH     = 32,
   parameter int MULDIV_EN = 1
) (
   input logic         clk,
   input logic         rst,
   execute_mc_if.slave bus
);
   localparam int SW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, FIN = 2'd2} state_t;

   state_t           state;
   logic [SW-1:0]    cnt;
   logic             valid_q;
   logic [WIDTH-1:0] pc_q, y_q, st_q;
   logic [31:0]      ir_q;

   // Iteration registers: acc = partial product / remainder,
   // opnd = multiplicand / divisor, mreg = multiplier / quotient.
   logic [WIDTH-1:0] acc, opnd, mreg;
   logic             md_div, md_neg, md_dz;

   logic [5:0]       op;
   logic [3:0]       nib;
   logic [WIDTH-1:0] a, b, alu_y, a_mag, b_mag;
   logic [SW-1:0]    shamt;
   logic             is_md;

   assign op    = bus.ir_exec_next[31:26];
   assign nib   = op[3:0];
   assign a     = bus.a_exec_next;
   assign b     = bus.b_exec_next;
   assign shamt = b[SW-1:0];
   assign a_mag = a[WIDTH-1] ? -a : a;
   assign b_mag = b[WIDTH-1] ? -b : b;
   assign is_md = (MULDIV_EN != 0) && op[5] && (nib == 4'h2 || nib == 4'h3);

   // Upstream holds while a MUL/DIV has not reached its finishing cycle.
   assign bus.stall_exec = bus.stall_mem |
                           (bus.valid_exec_next & is_md & ~bus.flush_exec &
                            (state != FIN));

   // Single-cycle result; MUL/DIV nibbles yield 0 here (used when MULDIV_EN=0).
   always_comb begin
      alu_y = '0;
      if (op[5]) begin
         case (nib)
            4'h0: alu_y = a + b;
            4'h1: alu_y = a - b;
            4'h4: alu_y = {{(WIDTH-1){1'b0}}, a == b};
            4'h5: alu_y = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            4'h6: alu_y = {{(WIDTH-1){1'b0}}, $signed(a) <= $signed(b)};
            4'h8: alu_y = a & b;
            4'h9: alu_y = a | b;
            4'hA: alu_y = a ^ b;
            4'hB: alu_y = ~(a ^ b);
            4'hC: alu_y = a << shamt;
            4'hD: alu_y = a >> shamt;
            4'hE: alu_y = $signed(a) >>> shamt;
            default: alu_y = '0;
         endcase
      end else if (op == 6'h1B || op == 6'h1C || op == 6'h1D) begin
         alu_y = bus.pc_exec_next;
      end else begin
         alu_y = a + b;
      end
   end

   // One multiply step adds the multiplicand when the multiplier LSB is set;
   // one divide step shifts the next dividend bit into the remainder and
   // subtracts the divisor when that does not borrow.
   logic [WIDTH-1:0] mul_sum, rem_diff, md_mag, md_res;
   logic [WIDTH:0]   rem_sh;
   logic             rem_borrow;

   assign mul_sum                = acc + (mreg[0] ? opnd : '0);
   assign rem_sh                 = {acc, mreg[WIDTH-1]};
   assign {rem_borrow, rem_diff} = rem_sh - {1'b0, opnd};
   assign md_mag                 = md_div ? mreg : acc;
   assign md_res                 = md_dz ? '1 : (md_neg ? -md_mag : md_mag);

   // Stage registers and MUL/DIV sequencer; stall_mem freezes everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         valid_q <= 1'b0;
         pc_q    <= '0;
         ir_q    <= '0;
         y_q     <= '0;
         st_q    <= '0;
         acc     <= '0;
         opnd    <= '0;
         mreg    <= '0;
         md_div  <= 1'b0;
         md_neg  <= 1'b0;
         md_dz   <= 1'b0;
      end else if (!bus.stall_mem) begin
         if (bus.flush_exec || !bus.valid_exec_next) begin
            state   <= IDLE;
            cnt     <= '0;
            valid_q <= 1'b0;
            ir_q    <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (is_md) begin
                     md_div  <= nib[0];
                     md_neg  <= a[WIDTH-1] ^ b[WIDTH-1];
                     md_dz   <= nib[0] && (b == '0);
                     acc     <= '0;
                     opnd    <= nib[0] ? b_mag : a_mag;
                     mreg    <= nib[0] ? a_mag : b_mag;
                     cnt     <= SW'(WIDTH - 1);
                     state   <= BUSY;
                     valid_q <= 1'b0;
                     ir_q    <= '0;
                  end else begin
                     valid_q <= 1'b1;
                     pc_q    <= bus.pc_exec_next;
                     ir_q    <= bus.ir_exec_next;
                     y_q     <= alu_y;
                     st_q    <= bus.st_exec_next;
                  end
               end
               BUSY: begin
                  if (md_div) begin
                     acc  <= rem_borrow ? rem_sh[WIDTH-1:0] : rem_diff;
                     mreg <= {mreg[WIDTH-2:0], ~rem_borrow};
                  end else begin
                     acc  <= mul_sum;
                     opnd <= opnd << 1;
                     mreg <= mreg >> 1;
                  end
                  if (cnt == '0) state <= FIN;
                  else           cnt   <= cnt - 1'b1;
                  valid_q <= 1'b0;
                  ir_q    <= '0;
               end
               FIN: begin
                  valid_q <= 1'b1;
                  pc_q    <= bus.pc_exec_next;
                  ir_q    <= bus.ir_exec_next;
                  y_q     <= md_res;
                  st_q    <= bus.st_exec_next;
                  state   <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.valid_mem_next = valid_q;
   assign bus.pc_mem_next    = pc_q;
   assign bus.ir_mem_next    = ir_q;
   assign bus.y_mem_next     = y_q;
   assign bus.st_mem_next    = st_q;
   assign bus.fsm_state      = state;
endmodule

// File: doc/execute_mc.md
# execute_mc

Parametrised execute stage for the Beta pipeline, sitting between the register-read stage and the memory stage. Single-cycle ALU operations complete in one cycle, as in the current execute stage. MUL and DIV are computed by an iterative shift-add / restoring-divide unit that stalls the upstream pipeline. The stage adds valid tracking, a downstream stall input and a flush input.

## Interface
- WIDTH, 32, datapath width of a/b/y/st/pc (IR stays 32 bits)
- MULDIV_EN, 1, 1 = iterative MUL/DIV present; 0 = MUL/DIV opcodes produce y = 0 in one cycle
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- valid_exec_next  in  1  instruction on *_exec_next inputs is valid
- pc_exec_next  in  WIDTH  PC+4 of instruction
- ir_exec_next  in  32  instruction word; opcode = ir[31:26]
- a_exec_next  in  WIDTH  operand A (forwarded)
- b_exec_next  in  WIDTH  operand B (literal forms: decode supplies sign-extended literal)
- st_exec_next  in  WIDTH  store data, passed through
- flush_exec  in  1  annul instruction in this stage, including in-flight MUL/DIV
- stall_mem  in  1  downstream cannot accept; freeze stage
- stall_exec  out  1  upstream must hold its outputs this cycle (combinational)
- valid_mem_next, pc_mem_next, ir_mem_next, y_mem_next, st_mem_next  out  1/WIDTH/32/WIDTH/WIDTH  registered stage outputs

## Operation
- Op select by ir[31:26]. ALU classes 10xxxx (register) and 11xxxx (literal) share low-nibble decode: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 CMPEQ, 5 CMPLT (signed), 6 CMPLE (signed), 8 AND, 9 OR, A XOR, B XNOR, C SHL, D SHR, E SRA; undefined nibbles -> y = 0.
- Compares produce 0 or 1. Shifts use b[log2(WIDTH)-1:0]. Add/sub wrap modulo 2^WIDTH.
- Opcodes 0x1B-0x1D (JMP/BEQ/BNE): y = pc_exec_next. All other non-ALU opcodes (LD, ST, LDR, ...): y = a + b.
- MUL: low WIDTH bits of product; iterate unsigned over |a|, |b|, then negate if signs differ.
- DIV: signed quotient truncated toward zero via restoring division on magnitudes. Divide by 0 -> all ones. Most-negative / -1 -> most-negative.
- FSM (MULDIV_EN=1):
  - IDLE: valid MUL/DIV present -> latch magnitudes, signs, opcode; cnt = WIDTH-1; go BUSY.
  - BUSY: one bit per cycle; cnt==0 -> FIN, else cnt-1.
  - FIN: sign-fixed result loaded into output registers together with pc/ir/st; go IDLE.
- stall_exec = stall_mem | (valid MUL/DIV and state != FIN). The instruction is consumed at the FIN edge.
- During IDLE-issue and BUSY, output registers load a bubble: valid_mem_next = 0, ir_mem_next = 0, others hold.

## Timing
- Reset: all outputs 0, valid_mem_next 0, FSM IDLE, cnt 0, stall_exec = stall_mem only.
- Single-cycle op presented in cycle n: outputs valid after edge ending cycle n.
- MUL/DIV presented in cycle n: stall_exec high cycles n..n+WIDTH. Result valid after edge ending cycle n+WIDTH+1. Latency WIDTH+2.
- stall_mem high: all output registers, FSM and cnt hold; stall_exec high.
- flush_exec high: FSM -> IDLE, cnt cleared, stall_exec low unless stall_mem. If not stall_mem, outputs load a bubble. Flush has priority over issue; rst has priority over everything.
- valid_exec_next low: bubble into output (if not stall_mem); FSM unaffected only in IDLE.
- Back-to-back MUL after MUL: the second issues in the cycle after FIN; no dead cycle.
- rst mid-BUSY: abort, no result emitted.

## Test plan
- ADD a=1 b=2 -> y=3, valid_mem_next=1 one edge later; SUB 0 - 1 -> 0xFFFFFFFF; CMPLT 0xFFFFFFFF,1 -> 1; SRA 0x80000000 by 4 -> 0xF8000000.
- MUL a=-3 b=7 -> stall_exec high 33 cycles, y=0xFFFFFFEB at cycle 34, bubbles before; MUL 0x10000 x 0x10000 -> 0.
- DIV 7/-2 -> 0xFFFFFFFD; DIV 5/0 -> 0xFFFFFFFF; DIV 0x80000000/-1 -> 0x80000000.
- stall_mem asserted 3 cycles mid-DIV -> outputs frozen, result delayed exactly 3 cycles, value unchanged.
- flush_exec at BUSY cycle 10 -> FSM IDLE, stall_exec drops next cycle, no valid output; following ADD completes normally.
- rst mid-MUL -> all outputs 0, valid 0 next edge; JMP with pc=0x104 -> y=0x104; LD a=0x100 b=8 -> y=0x108.
